// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the select-driven round-robin arbiter.
// Index helpers are sized for the largest supported requester count (16).
package sel_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {IDLE, BUSY, PARK} state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    // Walk downward so the closest set bit after last is the final assignment;
    // k == n lands on last itself, which lets a sole requester win again.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last,
                                                 input int                 n);
        logic [IDX_W-1:0] idx;
        int               j;
        idx = last;
        for (int k = n; k >= 1; k--) begin
            j = (int'(last) + k) % n;
            if (req[j]) idx = IDX_W'(j);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sel_rr_arbiter_pick.sv
// Combinational rotate-priority encoder: first set req bit after last, with wrap.
import sel_arb_pkg::*;

module sel_rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [IDX_W-1:0] pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), IDX_W'(last), NUM_REQ);
        winner = SEL_W'(pick);
        found  = |req;
    end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter with hold timeout for a shared select-decoded resource.
// Optional X/Z screening of req compiled in with SEL_ARB_XZ_CHECK_EN.
import sel_arb_pkg::*;

module sel_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int SEL_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               timeout,
    output logic               xz_err
);

    state_t             state, state_nxt;
    logic [7:0]         cnt;
    logic [SEL_W-1:0]   last;
    logic [NUM_REQ-1:0] req_eff;
    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               owner_req, owner_done, hit_max, rel, to_only;

`ifdef SEL_ARB_XZ_CHECK_EN
    // Unknown request bits never win arbitration.
    always_comb begin
        req_eff = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_eff[i] = (req[i] === 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xz_err <= 1'b0;
        end else if ((^req) === 1'bx) begin
            xz_err <= 1'b1;
            $display("sel_rr_arbiter: X/Z on req bits %b", req);
        end
    end
`else
    assign req_eff = req;
    assign xz_err  = 1'b0;
`endif

    sel_rr_arbiter_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
        .req    (req_eff),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    // sel is re-encoded from the one-hot grant so the two can never disagree.
    always_comb begin
        gnt_nxt    = NUM_REQ'(1) << winner;
        sel_nxt    = SEL_W'(onehot_to_idx(MAX_REQ'(gnt_nxt)));
        owner_req  = |(gnt & req_eff);
        owner_done = |(gnt & done);
        hit_max    = (cnt == 8'(MAX_HOLD - 1));
        rel        = !owner_req || owner_done || hit_max;
        to_only    = hit_max && owner_req && !owner_done;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BUSY;
            BUSY:    if (rel)   state_nxt = PARK;
            PARK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            timeout   <= 1'b0;
            last      <= SEL_W'(NUM_REQ - 1);
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    gnt       <= gnt_nxt;
                    sel       <= sel_nxt;
                    sel_valid <= 1'b1;
                    last      <= sel_nxt;
                    cnt       <= '0;
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (rel) begin
                        gnt       <= '0;
                        sel_valid <= 1'b0;
                        timeout   <= to_only;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Scoreboard bench for sel_rr_arbiter (NUM_REQ=4, MAX_HOLD=8).
`timescale 1ns/1ps
module tb_sel_rr_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid, timeout, xz_err;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    sel_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .timeout   (timeout),
        .xz_err    (xz_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] s);
        exp_t e;
        e.gnt = g;
        e.sel = s;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = '0;
        tick();
        rst = 1'b0;
    endtask

    // Advance until a grant appears, then pop the scoreboard and compare.
    task automatic wait_grant(input string name, input int budget, output int cyc);
        exp_t e;
        cyc = 0;
        while (!sel_valid && cyc < budget) begin
            tick();
            cyc++;
        end
        checks++;
        if (!sel_valid) begin
            errors++;
            $display("FAIL %s no_grant: got sel_valid=%b after %0d cycles, required 1", name, sel_valid, cyc);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_grant: got gnt=%b, required none", name, gnt);
        end else begin
            e = exp_q.pop_front();
            if (gnt !== e.gnt || sel !== e.sel) begin
                errors++;
                $display("FAIL %s grant: got gnt=%b sel=%0d, required gnt=%b sel=%0d", name, gnt, sel, e.gnt, e.sel);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = '0;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0 || sel !== 2'd0 || sel_valid !== 1'b0 || timeout !== 1'b0 || xz_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got gnt=%b sel=%0d v=%b to=%b xz=%b, required all 0",
                     gnt, sel, sel_valid, timeout, xz_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        do_reset();
        req = 4'b0100;
        push(4'b0100, 2'd2);
        wait_grant("rst_mid", 10, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL rst_mid latency: got %0d cycles, required 1", cyc);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0 || sel !== 2'd0 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid clear: got gnt=%b sel=%0d v=%b, required 0000/0/0", gnt, sel, sel_valid);
        end
        rst = 1'b0;
        push(4'b0100, 2'd2);
        wait_grant("rst_mid_regrant", 1, cyc);
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_rotation();
        int         cyc;
        logic [3:0] owner;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push(4'b0001 << (k % 4), 2'(k % 4));
        for (int k = 0; k < 5; k++) begin
            owner = 4'b0001 << (k % 4);
            wait_grant("rotation", 20, cyc);
            if (k > 0) begin
                checks++;
                if (cyc !== 2) begin
                    errors++;
                    $display("FAIL rotation gap: got %0d cycles, required 2", cyc);
                end
            end
            tick();
            tick();
            done = owner;
            checks++;
            if (gnt !== owner) begin
                errors++;
                $display("FAIL rotation hold: got gnt=%b, required %b", gnt, owner);
            end
            tick();
            done = '0;
            checks++;
            if (gnt !== 4'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rotation release: got gnt=%b to=%b, required 0000/0", gnt, timeout);
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int cyc;
        int hold;
        do_reset();
        req = 4'b0010;
        push(4'b0010, 2'd1);
        wait_grant("timeout", 10, cyc);
        hold = 1;
        while (hold < 20) begin
            tick();
            if (sel_valid) hold++;
            else break;
        end
        checks++;
        if (hold !== 8) begin
            errors++;
            $display("FAIL timeout hold: got %0d cycles, required 8", hold);
        end
        checks++;
        if (timeout !== 1'b1 || sel !== 2'd1) begin
            errors++;
            $display("FAIL timeout pulse: got to=%b sel=%0d, required 1/1", timeout, sel);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout width: got to=%b, required 0", timeout);
        end
        push(4'b0010, 2'd1);
        wait_grant("timeout_regrant", 10, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL timeout regrant gap: got %0d, required 1 more cycle", cyc);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_collision();
        int cyc;
        do_reset();
        req = 4'b0010;
        push(4'b0010, 2'd1);
        wait_grant("collision", 10, cyc);
        repeat (7) tick();
        done = 4'b0010;
        tick();
        done = '0;
        checks++;
        if (gnt !== 4'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL collision: got gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_nonowner_done();
        int cyc;
        do_reset();
        req = 4'b0001;
        push(4'b0001, 2'd0);
        wait_grant("nonowner", 10, cyc);
        done = 4'b0100;
        repeat (2) begin
            tick();
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL nonowner done: got gnt=%b, required 0001", gnt);
            end
        end
        done = '0;
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_xz();
        int cyc;
        do_reset();
`ifdef SEL_ARB_XZ_CHECK_EN
        req = 4'b1x0z;
        push(4'b1000, 2'd3);
        wait_grant("xz_grant", 10, cyc);
        checks++;
        if (xz_err !== 1'b1) begin
            errors++;
            $display("FAIL xz_err set: got %b, required 1", xz_err);
        end
        req = '0;
        repeat (3) tick();
        checks++;
        if (xz_err !== 1'b1) begin
            errors++;
            $display("FAIL xz_err sticky: got %b, required 1", xz_err);
        end
`else
        req = 4'b1000;
        push(4'b1000, 2'd3);
        wait_grant("xz_grant", 10, cyc);
        req = '0;
        repeat (3) tick();
        checks++;
        if (xz_err !== 1'b0) begin
            errors++;
            $display("FAIL xz_err tied: got %b, required 0", xz_err);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0;
        test_reset();
        test_reset_mid_grant();
        test_rotation();
        test_timeout();
        test_collision();
        test_nonowner_done();
        test_xz();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Grant must be zero or one-hot and agree with sel while valid.
    always @(negedge clk) begin
        if (!rst && sel_valid === 1'b1) begin
            checks++;
            if ($countones(gnt) != 1 || gnt !== (4'b0001 << sel)) begin
                errors++;
                $display("FAIL onehot: got gnt=%b sel=%0d, required one-hot matching sel", gnt, sel);
            end
        end
    end

endmodule
